// File: rtl/merge_sort_pkg.sv
// rtl/merge_sort_pkg.sv - shared widths, sample/beat types and feeder FSM states
package merge_sort_pkg;

    localparam int SAMPLE_W         = 8;
    localparam int LANES            = 4;
    localparam int BEATS            = 8;
    localparam int BLK_LEN          = 32;
    localparam int CNT_W            = $clog2(BLK_LEN + 1);
    localparam int IDX_W            = $clog2(BLK_LEN);
    localparam int BEAT_W           = $clog2(BEATS);
    localparam int MIN_PERIOD_FLOOR = BEATS + 1;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [LANES-1:0][SAMPLE_W-1:0] beat_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_BURST,
        ST_GAP
    } feed_state_t;

endpackage

// File: rtl/sort_block_feeder_if.sv
// rtl/sort_block_feeder_if.sv - sample stream in, BlkIn plus four-lane beats out
interface sort_block_feeder_if;
    import merge_sort_pkg::*;

    sample_t s_data;
    logic    s_valid;
    logic    s_ready;
    logic    flush;
    sample_t In1;
    sample_t In2;
    sample_t In3;
    sample_t In4;
    logic    BlkIn;
    logic    busy;

    modport master (
        output s_data, s_valid, flush,
        input  s_ready, In1, In2, In3, In4, BlkIn, busy
    );

    modport slave (
        input  s_data, s_valid, flush,
        output s_ready, In1, In2, In3, In4, BlkIn, busy
    );

endinterface

// File: rtl/feeder_bank.sv
// rtl/feeder_bank.sv - one 32-sample bank with fill count, full flag and padded beat read
module feeder_bank
    import merge_sort_pkg::*;
#(
    parameter sample_t PAD_VALUE = sample_t'(-128)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  sample_t           i_wr_data,
    input  logic              i_close,
    input  logic              i_release,
    input  logic [BEAT_W-1:0] i_beat,
    output beat_t             o_beat,
    output logic              o_full,
    output logic              o_full_nxt
);

    sample_t          r_mem [BLK_LEN];
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             w_wr;
    logic [CNT_W-1:0] w_count_nxt;

    assign w_wr   = i_wr_en && !r_full;
    assign o_full = r_full;

    always_comb begin
        w_count_nxt = r_count;
        o_full_nxt  = r_full;
        if (i_release) begin
            w_count_nxt = '0;
            o_full_nxt  = 1'b0;
        end else begin
            if (w_wr) begin
                w_count_nxt = r_count + CNT_W'(1);
            end
            // Same-edge sample is counted before the close; closing an empty bank does nothing.
            if ((w_count_nxt == CNT_W'(BLK_LEN)) || (i_close && (w_count_nxt != '0))) begin
                o_full_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_full  <= o_full_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_count[IDX_W-1:0]] <= i_wr_data;
        end
    end

    always_comb begin
        o_beat = '0;
        for (int l = 0; l < LANES; l++) begin
            if ((int'(i_beat) * LANES + l) < int'(r_count)) begin
                o_beat[l] = r_mem[IDX_W'(int'(i_beat) * LANES + l)];
            end else begin
                o_beat[l] = PAD_VALUE;
            end
        end
    end

endmodule

// File: rtl/sort_block_feeder.sv
// rtl/sort_block_feeder.sv - ping-pong sample buffer replaying full blocks as BlkIn plus 8 beats
module sort_block_feeder
    import merge_sort_pkg::*;
#(
    parameter sample_t PAD_VALUE  = sample_t'(-128),
    parameter int      MIN_PERIOD = 9
) (
    input  logic               clk,
    input  logic               rst,
    sort_block_feeder_if.slave s_if
);

    // A block needs BlkIn plus eight beats, so shorter periods are raised to that floor.
    localparam int PERIOD  = (MIN_PERIOD < MIN_PERIOD_FLOOR) ? MIN_PERIOD_FLOOR : MIN_PERIOD;
    localparam int SINCE_W = $clog2(PERIOD);

    feed_state_t        r_state;
    feed_state_t        w_state_nxt;
    logic [BEAT_W-1:0]  r_beat;
    logic [BEAT_W-1:0]  w_beat_nxt;
    logic [SINCE_W-1:0] r_since;
    logic               r_wr_bank;
    logic               r_rd_bank;
    logic               r_blk;
    beat_t              r_lanes;

    logic               w_xfer;
    logic               w_last_beat;
    logic               w_period_done;
    logic               w_wr_en     [2];
    logic               w_close     [2];
    logic               w_release   [2];
    logic               w_full      [2];
    logic               w_full_nxt  [2];
    beat_t              w_bank_beat [2];

    assign w_xfer        = s_if.s_valid && s_if.s_ready;
    assign w_last_beat   = (r_state == ST_BURST) && (r_beat == BEAT_W'(BEATS - 1));
    assign w_period_done = (r_since >= SINCE_W'(PERIOD - 1));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign w_wr_en[b]   = w_xfer && (r_wr_bank == 1'(b));
        assign w_close[b]   = s_if.flush && (r_wr_bank == 1'(b));
        assign w_release[b] = w_last_beat && (r_rd_bank == 1'(b));

        feeder_bank #(
            .PAD_VALUE (PAD_VALUE)
        ) u_bank (
            .clk        (clk),
            .rst        (rst),
            .i_wr_en    (w_wr_en[b]),
            .i_wr_data  (s_if.s_data),
            .i_close    (w_close[b]),
            .i_release  (w_release[b]),
            .i_beat     (w_beat_nxt),
            .o_beat     (w_bank_beat[b]),
            .o_full     (w_full[b]),
            .o_full_nxt (w_full_nxt[b])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        unique case (r_state)
            ST_IDLE: begin
                if (w_full_nxt[r_rd_bank]) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                w_state_nxt = ST_BURST;
                w_beat_nxt  = '0;
            end
            ST_BURST: begin
                if (w_last_beat) begin
                    // The other bank becomes the read bank at this edge, so its fill decides a back-to-back start.
                    if (!w_period_done) begin
                        w_state_nxt = ST_GAP;
                    end else if (w_full_nxt[~r_rd_bank]) begin
                        w_state_nxt = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_beat_nxt = r_beat + BEAT_W'(1);
                end
            end
            ST_GAP: begin
                if (w_period_done) begin
                    w_state_nxt = w_full_nxt[r_rd_bank] ? ST_START : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_beat    <= '0;
            r_since   <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_blk     <= 1'b0;
            r_lanes   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            if (w_state_nxt == ST_START) begin
                r_since <= '0;
            end else if (!w_period_done) begin
                r_since <= r_since + SINCE_W'(1);
            end
            if (w_full_nxt[r_wr_bank] && !w_full[r_wr_bank]) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_last_beat) begin
                r_rd_bank <= ~r_rd_bank;
            end
            // Outputs are loaded from the next state so they line up with the state they describe.
            r_blk   <= (w_state_nxt == ST_START);
            r_lanes <= (w_state_nxt == ST_BURST) ? w_bank_beat[r_rd_bank] : '0;
        end
    end

    assign s_if.s_ready = !w_full[r_wr_bank];
    assign s_if.busy    = (r_state == ST_START) || (r_state == ST_BURST) || w_full[0] || w_full[1];
    assign s_if.BlkIn   = r_blk;
    assign s_if.In1     = sample_t'(r_lanes[0]);
    assign s_if.In2     = sample_t'(r_lanes[1]);
    assign s_if.In3     = sample_t'(r_lanes[2]);
    assign s_if.In4     = sample_t'(r_lanes[3]);

endmodule

// File: tb/tb_sort_block_feeder.sv
// tb/tb_sort_block_feeder.sv - scoreboard bench for sort_block_feeder
module tb_sort_block_feeder;
    import merge_sort_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sort_block_feeder_if bus_if();

    sort_block_feeder #(
        .PAD_VALUE  (sample_t'(-128)),
        .MIN_PERIOD (9)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .s_if (bus_if)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [255:0] exp_q[$];
    int           blk_times[$];
    logic [255:0] m_blk = '0;
    int           m_cnt = 0;
    int           last_wr_cyc = 0;
    int           stall_cycles = 0;
    int           ready_cyc = 0;
    bit           in_burst = 0;
    int           mon_beat = 0;
    logic [255:0] mon_cur = '0;
    logic [31:0]  lanes;

    assign lanes = {bus_if.In4, bus_if.In3, bus_if.In2, bus_if.In1};

    function automatic void check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic void m_close();
        for (int i = m_cnt; i < 32; i++) m_blk[i*8 +: 8] = 8'h80;
        exp_q.push_back(m_blk);
        m_cnt = 0;
    endfunction

    function automatic void m_write(input logic [7:0] v);
        m_blk[m_cnt*8 +: 8] = v;
        m_cnt++;
        if (m_cnt == 32) m_close();
    endfunction

    function automatic void m_flush();
        if (m_cnt > 0) m_close();
    endfunction

    // Called and returning at a falling edge; the transfer happens on the rising edge in between.
    task automatic send(input int v, input bit fl);
        int t = 0;
        bus_if.s_data  = sample_t'(v);
        bus_if.s_valid = 1'b1;
        bus_if.flush   = fl;
        while (!bus_if.s_ready && t < 200) begin
            @(negedge clk);
            t++;
            stall_cycles++;
            if (bus_if.s_ready) ready_cyc = cyc;
        end
        check("send_ready", int'(bus_if.s_ready), 1);
        last_wr_cyc = cyc;
        m_write(v[7:0]);
        if (fl) m_flush();
        @(negedge clk);
        bus_if.s_valid = 1'b0;
        bus_if.flush   = 1'b0;
    endtask

    task automatic flush_only();
        bus_if.flush = 1'b1;
        m_flush();
        @(negedge clk);
        bus_if.flush = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || in_burst || bus_if.busy) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check(name, int'(exp_q.size() == 0 && !bus_if.busy), 1);
    endtask

    task automatic wait_blocks(input int n, input string name);
        int t = 0;
        while (blk_times.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        check(name, int'(blk_times.size() >= n), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        m_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_blkin"}, int'(bus_if.BlkIn), 0);
        check({tag, "_lanes"}, int'(lanes), 0);
        check({tag, "_busy"}, int'(bus_if.busy), 0);
        check({tag, "_s_ready"}, int'(bus_if.s_ready), 1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            in_burst = 0;
            mon_beat = 0;
        end else if (in_burst) begin
            check($sformatf("beat%0d_data", mon_beat), int'(lanes), int'(mon_cur[mon_beat*32 +: 32]));
            check("blkin_in_burst", int'(bus_if.BlkIn), 0);
            mon_beat++;
            if (mon_beat == 8) in_burst = 0;
        end else if (bus_if.BlkIn) begin
            check("blkin_expected", int'(exp_q.size() > 0), 1);
            check("lanes_at_blkin", int'(lanes), 0);
            blk_times.push_back(cyc);
            if (exp_q.size() > 0) begin
                mon_cur  = exp_q.pop_front();
                in_burst = 1;
                mon_beat = 0;
            end
        end else begin
            check("lanes_idle", int'(lanes), 0);
        end
    end

    initial begin
        int nb;
        int c0;
        bus_if.s_data  = '0;
        bus_if.s_valid = 1'b0;
        bus_if.flush   = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        // Single block 0..31
        for (int i = 0; i < 32; i++) send(i, 1'b0);
        check("single_blkin_now", int'(bus_if.BlkIn), 1);
        check("single_busy", int'(bus_if.busy), 1);
        wait_blocks(1, "single_blk_seen");
        if (blk_times.size() >= 1) check("single_blk_cycle", blk_times[0], last_wr_cyc + 1);
        drain("single_drain");

        // Partial block closed by flush
        nb = blk_times.size();
        send(-5, 1'b0);
        send(7, 1'b0);
        send(100, 1'b0);
        flush_only();
        wait_blocks(nb + 1, "flush_blk_seen");
        drain("flush_drain");

        nb = blk_times.size();
        flush_only();
        repeat (12) @(negedge clk);
        check("empty_flush_no_blk", blk_times.size(), nb);
        check("empty_flush_busy", int'(bus_if.busy), 0);

        // Both banks closed back to back: s_ready stalls, BlkIn spaced by the minimum period
        nb = blk_times.size();
        stall_cycles = 0;
        send(11, 1'b1);
        c0 = last_wr_cyc;
        send(22, 1'b1);
        send(33, 1'b0);
        check("bp_stall_cycles", stall_cycles, 8);
        check("bp_ready_cycle", ready_cyc, c0 + 10);
        flush_only();
        wait_blocks(nb + 3, "bp_blks_seen");
        if (blk_times.size() >= nb + 2) begin
            check("bp_first_blk", blk_times[nb], c0 + 1);
            check("bp_period", blk_times[nb+1] - blk_times[nb], 9);
        end
        drain("bp_drain");

        // Transfer and flush on the same edge after 31 writes
        nb = blk_times.size();
        for (int i = 0; i < 31; i++) send(i * 3 - 40, 1'b0);
        send(77, 1'b1);
        wait_blocks(nb + 1, "same_edge_blk_seen");
        drain("same_edge_drain");
        repeat (10) @(negedge clk);
        check("same_edge_single_blk", blk_times.size(), nb + 1);

        // 96 samples at one per cycle
        nb = blk_times.size();
        stall_cycles = 0;
        for (int i = 0; i < 96; i++) send((i * 37) & 8'hFF, 1'b0);
        check("stream_no_stall", stall_cycles, 0);
        wait_blocks(nb + 3, "stream_blks_seen");
        if (blk_times.size() >= nb + 3) begin
            check("stream_spacing1", blk_times[nb+1] - blk_times[nb], 32);
            check("stream_spacing2", blk_times[nb+2] - blk_times[nb+1], 32);
        end
        drain("stream_drain");

        // Reset during beat 3
        for (int i = 0; i < 32; i++) send(i - 16, 1'b0);
        check("rb_blkin", int'(bus_if.BlkIn), 1);
        repeat (4) @(negedge clk);
        check("rb_beat3_in1", int'(bus_if.In1), -4);
        do_reset();
        check_reset_state("rb_after");
        nb = blk_times.size();
        for (int i = 0; i < 32; i++) send(60 - i * 2, 1'b0);
        wait_blocks(nb + 1, "rb_new_blk_seen");
        drain("rb_drain");

        // Signed extremes
        for (int i = 0; i < 32; i++) send((i % 2 == 1) ? 127 : -128, 1'b0);
        drain("extremes_drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (errors %0d)", n_errors);
        $fatal(1);
    end

endmodule
